// File: rtl/rvsteel_uart_pkg.sv
// Shared UART definitions: register map, status bit and TX arbiter FSM encoding.
package rvsteel_uart_pkg;

  localparam int unsigned GRANT_W = 2;
  localparam int unsigned TIMER_W = 16;

  localparam logic [31:0] UART_TX_OFFSET = 32'h0000_0000;
  localparam logic [31:0] UART_RX_OFFSET = 32'h0000_0004;

  localparam int unsigned UART_STATUS_TX_IDLE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_POLL        = 3'd1,
    ST_WAIT_STATUS = 3'd2,
    ST_WRITE       = 3'd3,
    ST_WAIT_WRITE  = 3'd4
  } tx_state_t;

  // States in which the response timer runs.
  function automatic logic is_wait_state(input tx_state_t s);
    return (s == ST_WAIT_STATUS) || (s == ST_WAIT_WRITE);
  endfunction

endpackage

// File: rtl/rvsteel_rr_arbiter.sv
// Combinational round-robin picker; the last-grant pointer is held by the parent.
module rvsteel_rr_arbiter
  import rvsteel_uart_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]       request,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [N-1:0]       grant,
  output logic [GRANT_W-1:0] grant_index
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [2:0]       sum;
  logic [IDX_W-1:0] candidate;
  logic             found;

  // Search from last_grant+1 upward, wrapping modulo N; first hit wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    sum         = '0;
    candidate   = '0;
    for (int unsigned offset = 1; offset <= N; offset++) begin
      sum = 3'(last_grant) + 3'(offset);
      if (sum >= 3'(N)) sum = sum - 3'(N);
      candidate = IDX_W'(sum);
      if (!found && request[candidate]) begin
        found            = 1'b1;
        grant[candidate] = 1'b1;
        grant_index      = GRANT_W'(candidate);
      end
    end
  end

endmodule

// File: rtl/rvsteel_uart_tx_arbiter.sv
// Shares the UART transmitter among several byte requesters: round-robin accept,
// poll TX status until idle, then write the byte, with a response timeout.
module rvsteel_uart_tx_arbiter
  import rvsteel_uart_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS    = 2,
  parameter logic [31:0] UART_BASE_ADDRESS = 32'h8000_0000,
  parameter int unsigned RESPONSE_TIMEOUT  = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQUESTERS-1:0]     req_valid,
  input  logic [8*NUM_REQUESTERS-1:0]   req_data,
  output logic [NUM_REQUESTERS-1:0]     req_ready,
  output logic [31:0]                   rw_address,
  output logic                          read_request,
  input  logic [31:0]                   read_data,
  input  logic                          read_response,
  output logic [7:0]                    write_data,
  output logic                          write_request,
  input  logic                          write_response,
  output logic                          busy,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          timeout_error
);

  localparam logic [31:0] TX_ADDRESS = UART_BASE_ADDRESS + UART_TX_OFFSET;

  if (NUM_REQUESTERS < 1 || NUM_REQUESTERS > 4) begin : g_bad_num_requesters
    $error("NUM_REQUESTERS must be 1 to 4");
  end
  if (RESPONSE_TIMEOUT < 1 || RESPONSE_TIMEOUT > 65535) begin : g_bad_timeout
    $error("RESPONSE_TIMEOUT must be 1 to 65535");
  end

  tx_state_t state, state_next;

  logic [GRANT_W-1:0]        last_grant, last_grant_next;
  logic [7:0]                tx_byte, tx_byte_next;
  logic [TIMER_W-1:0]        wait_count, wait_count_next;

  logic [NUM_REQUESTERS-1:0] req_ready_next;
  logic [31:0]               rw_address_next;
  logic                      read_request_next;
  logic [7:0]                write_data_next;
  logic                      write_request_next;
  logic                      busy_next;
  logic [GRANT_W-1:0]        grant_id_next;
  logic                      timeout_error_next;

  logic [NUM_REQUESTERS-1:0] arb_grant;
  logic [GRANT_W-1:0]        arb_index;
  logic                      transfer;
  logic                      timed_out;
  logic                      tx_idle;
  logic [7:0]                granted_byte;
  logic [8*(NUM_REQUESTERS+1)-1:0] byte_fold;
  logic                      unused_read_bits;

  rvsteel_rr_arbiter #(
    .N (NUM_REQUESTERS)
  ) u_rr_arbiter (
    .request     (req_valid),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_index (arb_index)
  );

  // OR-fold of the byte offered by whichever requester currently holds req_ready.
  assign byte_fold[7:0] = '0;
  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_byte_fold
    assign byte_fold[8*(g+1) +: 8] = byte_fold[8*g +: 8] |
                                     (req_data[8*g +: 8] & {8{req_ready[g]}});
  end
  assign granted_byte = byte_fold[8*NUM_REQUESTERS +: 8];

  assign transfer         = |(req_valid & req_ready);
  assign timed_out        = (wait_count == TIMER_W'(RESPONSE_TIMEOUT - 1));
  assign tx_idle          = read_data[UART_STATUS_TX_IDLE_BIT];
  assign unused_read_bits = ^read_data[31:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= GRANT_W'(NUM_REQUESTERS - 1);
      tx_byte       <= '0;
      wait_count    <= '0;
      req_ready     <= '0;
      rw_address    <= '0;
      read_request  <= 1'b0;
      write_data    <= '0;
      write_request <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= '0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_next;
      last_grant    <= last_grant_next;
      tx_byte       <= tx_byte_next;
      wait_count    <= wait_count_next;
      req_ready     <= req_ready_next;
      rw_address    <= rw_address_next;
      read_request  <= read_request_next;
      write_data    <= write_data_next;
      write_request <= write_request_next;
      busy          <= busy_next;
      grant_id      <= grant_id_next;
      timeout_error <= timeout_error_next;
    end
  end

  // Next state plus the values every output register takes on the next edge.
  always_comb begin
    state_next         = state;
    last_grant_next    = last_grant;
    tx_byte_next       = tx_byte;
    wait_count_next    = wait_count;
    req_ready_next     = '0;
    rw_address_next    = '0;
    read_request_next  = 1'b0;
    write_data_next    = '0;
    write_request_next = 1'b0;
    grant_id_next      = grant_id;
    timeout_error_next = timeout_error;

    case (state)
      ST_IDLE: begin
        if (transfer) begin
          tx_byte_next    = granted_byte;
          last_grant_next = grant_id;
          state_next      = ST_POLL;
        end
      end
      ST_POLL: state_next = ST_WAIT_STATUS;
      ST_WAIT_STATUS: begin
        if (read_response) begin
          state_next = tx_idle ? ST_WRITE : ST_POLL;
        end else if (timed_out) begin
          timeout_error_next = 1'b1;
          tx_byte_next       = '0;
          state_next         = ST_IDLE;
        end else begin
          wait_count_next = wait_count + TIMER_W'(1);
        end
      end
      ST_WRITE: state_next = ST_WAIT_WRITE;
      ST_WAIT_WRITE: begin
        if (write_response) begin
          state_next = ST_IDLE;
        end else if (timed_out) begin
          timeout_error_next = 1'b1;
          tx_byte_next       = '0;
          state_next         = ST_IDLE;
        end else begin
          wait_count_next = wait_count + TIMER_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next != state && is_wait_state(state_next)) wait_count_next = '0;

    // POLL and WRITE last one cycle, so these strobes are single pulses.
    if (state_next == ST_POLL) begin
      read_request_next = 1'b1;
      rw_address_next   = TX_ADDRESS;
    end
    if (state_next == ST_WRITE) begin
      write_request_next = 1'b1;
      rw_address_next    = TX_ADDRESS;
      write_data_next    = tx_byte;
    end

    busy_next = (state_next != ST_IDLE);

    // Offer the next grant as IDLE is (re)entered, unless a pulse is already out.
    if (state_next == ST_IDLE && (|req_valid) && !(state == ST_IDLE && (|req_ready))) begin
      req_ready_next = arb_grant;
      grant_id_next  = arb_index;
    end
  end

endmodule

// File: tb/tb_rvsteel_uart_tx_arbiter.sv
// Directed bench for rvsteel_uart_tx_arbiter with a small UART bus responder.
module tb_rvsteel_uart_tx_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [31:0] rw_address;
  logic        read_request;
  logic [31:0] read_data;
  logic        read_response;
  logic [7:0]  write_data;
  logic        write_request;
  logic        write_response;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_error;

  rvsteel_uart_tx_arbiter #(
    .NUM_REQUESTERS    (2),
    .UART_BASE_ADDRESS (BASE),
    .RESPONSE_TIMEOUT  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rw_address     (rw_address),
    .read_request   (read_request),
    .read_data      (read_data),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_request  (write_request),
    .write_response (write_response),
    .busy           (busy),
    .grant_id       (grant_id),
    .timeout_error  (timeout_error)
  );

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    int         busy_polls;
    logic [1:0] exp_grant;
    logic [7:0] exp_byte;
    int         exp_reads;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  int         cyc = 0;
  bit         monitor_on = 0;
  bit         withhold_write = 0;
  int         busy_left = 0;
  int         read_count = 0;
  int         write_count = 0;
  int         read_cycles[$];
  logic [7:0] wr_bytes[$];
  logic [1:0] wr_grants[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // UART responder: answers each strobe one cycle later; also watches bus rules.
  initial begin : uart_model
    bit pend_read, pend_write, strobe, prev_strobe;
    pend_read = 0; pend_write = 0; prev_strobe = 0;
    read_response = 1'b0; write_response = 1'b0; read_data = '0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      read_response  = pend_read;
      read_data      = (pend_read && busy_left == 0) ? 32'h0000_0001 : 32'hFFFF_FFFE;
      if (pend_read && busy_left > 0) busy_left--;
      write_response = pend_write && !withhold_write;
      pend_read  = (read_request === 1'b1);
      pend_write = (write_request === 1'b1);
      if (monitor_on) begin
        strobe = pend_read || pend_write;
        if (pend_read) begin
          read_count++;
          read_cycles.push_back(cyc);
        end
        if (pend_write) begin
          write_count++;
          wr_bytes.push_back(write_data);
          wr_grants.push_back(grant_id);
        end
        if (strobe) begin
          check("strobe_address", rw_address, BASE);
          check("strobe_back_to_back", 32'(prev_strobe), 32'd0);
        end else begin
          check("idle_address", rw_address, 32'd0);
        end
        prev_strobe = strobe;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rw_address"}, rw_address, 32'd0);
    check({tag, "_read_request"}, 32'(read_request), 32'd0);
    check({tag, "_write_request"}, 32'(write_request), 32'd0);
    check({tag, "_write_data"}, 32'(write_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_timeout_error"}, 32'(timeout_error), 32'd0);
  endtask

  // Offer bytes, wait for the ready pulse, then withdraw everything after the handshake.
  task automatic start_byte(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                            output logic [1:0] ready_seen);
    req_data  = {d1, d0};
    req_valid = v;
    ready_seen = '0;
    for (int n = 0; n < 10 && ready_seen == 2'b00; n++) begin
      step();
      ready_seen = req_ready;
    end
    step();
    req_valid = '0;
  endtask

  task automatic clear_model();
    read_count = 0;
    write_count = 0;
    read_cycles.delete();
    wr_bytes.delete();
    wr_grants.delete();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [1:0] seen;
    int n;
    clear_model();
    busy_left = v.busy_polls;
    start_byte(v.valid, v.d0, v.d1, seen);
    check({tag, "_ready"}, 32'(seen), 32'(2'b01 << v.exp_grant));
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    check({tag, "_writes"}, write_count, 32'd1);
    check({tag, "_reads"}, read_count, v.exp_reads);
    if (wr_bytes.size() > 0) begin
      check({tag, "_byte"}, 32'(wr_bytes[0]), 32'(v.exp_byte));
      check({tag, "_grant_id"}, 32'(wr_grants[0]), 32'(v.exp_grant));
    end
    for (int i = 1; i < read_cycles.size(); i++)
      check({tag, "_poll_spacing"}, read_cycles[i] - read_cycles[i-1], 32'd2);
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t post_reset;
    vec_t after_timeout;
    logic [1:0] seen;
    int n;

    // last_grant before each row shown on the right
    vecs[0] = '{2'b01, 8'h11, 8'h00, 0, 2'd0, 8'h11, 1};  // last 0
    vecs[1] = '{2'b11, 8'h22, 8'h33, 0, 2'd1, 8'h33, 1};  // last 0
    vecs[2] = '{2'b11, 8'h44, 8'h55, 2, 2'd0, 8'h44, 3};  // last 1
    vecs[3] = '{2'b10, 8'h00, 8'h66, 1, 2'd1, 8'h66, 2};  // last 0
    vecs[4] = '{2'b10, 8'h00, 8'h77, 0, 2'd1, 8'h77, 1};  // last 1
    vecs[5] = '{2'b11, 8'h88, 8'h99, 0, 2'd0, 8'h88, 1};  // last 1
    vecs[6] = '{2'b01, 8'hAA, 8'h00, 3, 2'd0, 8'hAA, 4};  // last 0
    post_reset    = '{2'b11, 8'hC3, 8'hD4, 0, 2'd0, 8'hC3, 1};
    after_timeout = '{2'b01, 8'h3C, 8'h00, 0, 2'd0, 8'h3C, 1};

    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (3) step();
    check_all_zero("reset");

    // Single byte with exact cycle timing
    reset = 1'b0;
    monitor_on = 1;
    clear_model();
    start_byte(2'b01, 8'h55, 8'h00, seen);
    check("single_ready", 32'(seen), 32'h1);
    check("single_c1_read_request", 32'(read_request), 32'd1);
    check("single_c1_address", rw_address, BASE);
    check("single_c1_busy", 32'(busy), 32'd1);
    step();
    check("single_c2_read_request", 32'(read_request), 32'd0);
    check("single_c2_write_request", 32'(write_request), 32'd0);
    step();
    check("single_c3_write_request", 32'(write_request), 32'd1);
    check("single_c3_write_data", 32'(write_data), 32'h55);
    check("single_c3_address", rw_address, BASE);
    step();
    check("single_c4_write_request", 32'(write_request), 32'd0);
    check("single_c4_busy", 32'(busy), 32'd1);
    step();
    check("single_c5_busy", 32'(busy), 32'd0);
    check("single_reads", read_count, 32'd1);
    check("single_writes", write_count, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting on a busy status
    clear_model();
    busy_left = 1000;
    start_byte(2'b10, 8'h00, 8'h5A, seen);
    check("midreset_ready", 32'(seen), 32'h2);
    check("midreset_poll", 32'(read_request), 32'd1);
    step();
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0;
    busy_left = 0;
    clear_model();
    repeat (4) step();
    check("midreset_no_write", write_count, 32'd0);
    run_txn(post_reset, "post_reset");

    // Contention: both requesters stream continuously from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    clear_model();
    req_data  = {8'hB2, 8'hA1};
    req_valid = 2'b11;
    n = 0;
    while (write_count < 4 && n < 60) begin
      step();
      n++;
    end
    req_valid = '0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("contention_count", 32'(wr_bytes.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < wr_bytes.size(); i++) begin
      check($sformatf("contention_byte%0d", i), 32'(wr_bytes[i]), (i % 2 == 0) ? 32'hA1 : 32'hB2);
      check($sformatf("contention_grant%0d", i), 32'(wr_grants[i]), 32'(i % 2));
    end

    // Timeout: write_response withheld, WAIT_WRITE entered at cycle 4
    clear_model();
    withhold_write = 1;
    start_byte(2'b01, 8'hE7, 8'h00, seen);
    step();
    step();
    check("timeout_c3_write_request", 32'(write_request), 32'd1);
    repeat (4) step();
    check("timeout_c7_error", 32'(timeout_error), 32'd0);
    check("timeout_c7_busy", 32'(busy), 32'd1);
    step();
    check("timeout_c8_error", 32'(timeout_error), 32'd1);
    check("timeout_c8_busy", 32'(busy), 32'd0);
    withhold_write = 0;
    run_txn(after_timeout, "after_timeout");
    check("timeout_sticky", 32'(timeout_error), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("timeout_cleared", 32'(timeout_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
